// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave frame endpoint.
package spi_pkg;

    localparam int unsigned SPI_WIDTH       = 16;
    localparam int unsigned SPI_SYNC_STAGES = 2;
    localparam int unsigned SPI_CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one extra register for rise/fall event detection.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned STAGES   = SPI_SYNC_STAGES,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync   = sync_q[STAGES-1];
    assign rise_c = sync & ~prev_q;
    assign fall_c = ~sync & prev_q;

endmodule

// File: rtl/spi_slave_frame.sv
// 16-bit SPI slave: synchronised pins, MSB-first shift in/out, valid/ack frame hand-off.
// Optional sticky overrun flag enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave_frame
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = SPI_WIDTH,
    parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic                 LOAD,
    input  logic                 SCLK,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [WIDTH-1:0]     STX_DAT,
    output logic [WIDTH-1:0]     SRX_DAT,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [WIDTH-1:0]     sr_STX,
    output logic [WIDTH-1:0]     sr_SRX,
    output logic [SPI_CNT_W-1:0] cb_bit
);

    localparam int unsigned      CNT_W    = SPI_CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic load_sync, load_rise_c, load_fall_c;
    logic sclk_sync, sclk_rise_c, sclk_fall_c;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_sync;
    logic [SYNC_STAGES:0]   flush_q;
    logic                   armed_q;
    logic                   capture_c;
    spi_state_t             state_q, state_nxt;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_load_sync (
        .clk    (clk),
        .rst_n  (RESET),
        .din    (LOAD),
        .sync   (load_sync),
        .rise_c (load_rise_c),
        .fall_c (load_fall_c)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (RESET),
        .din    (SCLK),
        .sync   (sclk_sync),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // MOSI needs only a level; arming waits for the synchronisers to flush
    // after reset and then for an idle bus, so a frame cut by reset is skipped.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            mosi_q  <= '0;
            flush_q <= '0;
            armed_q <= 1'b0;
        end else begin
            mosi_q  <= {mosi_q[SYNC_STAGES-2:0], MOSI};
            flush_q <= {flush_q[SYNC_STAGES-1:0], 1'b1};
            armed_q <= armed_q | (flush_q[SYNC_STAGES] & load_sync & ~sclk_sync);
        end
    end

    assign mosi_sync = mosi_q[SYNC_STAGES-1];
    assign capture_c = (state_q == DONE) && (cb_bit == CNT_FULL);
    assign MISO      = sr_STX[WIDTH-1];

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (armed_q && load_fall_c) state_nxt = SHIFT;
            SHIFT:   if (load_rise_c) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath; in SHIFT the SCLK event lands first so DONE sees the final count.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            sr_STX    <= '0;
            sr_SRX    <= '0;
            cb_bit    <= '0;
            SRX_DAT   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            busy      <= (state_nxt != IDLE);
            case (state_q)
                IDLE: begin
                    if (armed_q && load_fall_c) begin
                        sr_STX <= STX_DAT;
                        sr_SRX <= '0;
                        cb_bit <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise_c) begin
                        sr_SRX <= {sr_SRX[WIDTH-2:0], mosi_sync};
                        if (cb_bit != CNT_MAX) cb_bit <= cb_bit + CNT_W'(1);
                    end
                    if (sclk_fall_c) sr_STX <= {sr_STX[WIDTH-2:0], 1'b0};
                end
                DONE: begin
                    if (capture_c) SRX_DAT   <= sr_SRX;
                    else           frame_err <= 1'b1;
                end
                default: ;
            endcase

            if (capture_c)   rx_valid <= 1'b1;
            else if (rx_ack) rx_valid <= 1'b0;

`ifdef SPI_SLAVE_OVERRUN_EN
            if (capture_c && rx_valid) overrun <= 1'b1;
            else if (rx_ack)           overrun <= 1'b0;
`else
            overrun <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame with a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_slave_frame;

    localparam int W    = 16;
    localparam int HALF = 10;
    localparam int SET  = 6;
`ifdef SPI_SLAVE_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         RESET, LOAD, SCLK, MOSI, rx_ack;
    logic [W-1:0] STX_DAT;
    logic         MISO, rx_valid, frame_err, overrun, busy;
    logic [W-1:0] SRX_DAT, sr_STX, sr_SRX;
    logic [7:0]   cb_bit;

    int           n_checks = 0;
    int           n_errs   = 0;
    int           ferr_cycles = 0;
    int           rv_rises = 0;
    int           exp_ferr = 0;
    int           exp_rises = 0;
    logic [W-1:0] exp_dat = '0;
    logic         exp_valid = 1'b0;
    logic         exp_ovr = 1'b0;
    logic         exp_busy = 1'b0;
    logic         chk_en = 1'b0;
    logic         rv_q = 1'b0;
    logic [W-1:0] mw;
    int           r0;

    always #5 clk = ~clk;

    spi_slave_frame dut (
        .clk       (clk),
        .RESET     (RESET),
        .LOAD      (LOAD),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .STX_DAT   (STX_DAT),
        .SRX_DAT   (SRX_DAT),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .sr_STX    (sr_STX),
        .sr_SRX    (sr_SRX),
        .cb_bit    (cb_bit)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model in settled windows.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_srx_dat",   32'(SRX_DAT),   32'(exp_dat));
            check("cyc_rx_valid",  32'(rx_valid),  32'(exp_valid));
            check("cyc_overrun",   32'(overrun),   32'(exp_ovr));
            check("cyc_busy",      32'(busy),      32'(exp_busy));
            check("cyc_frame_err", 32'(frame_err), 32'(0));
        end
    end

    always @(negedge clk) begin
        if (RESET && frame_err) ferr_cycles++;
        if (rx_valid && !rv_q) rv_rises++;
        rv_q = rx_valid;
    end

    task automatic check_reset(input string tag);
        check({tag, "_miso"},      32'(MISO),      32'(0));
        check({tag, "_srx_dat"},   32'(SRX_DAT),   32'(0));
        check({tag, "_rx_valid"},  32'(rx_valid),  32'(0));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(0));
        check({tag, "_overrun"},   32'(overrun),   32'(0));
        check({tag, "_busy"},      32'(busy),      32'(0));
        check({tag, "_sr_stx"},    32'(sr_STX),    32'(0));
        check({tag, "_sr_srx"},    32'(sr_SRX),    32'(0));
        check({tag, "_cb_bit"},    32'(cb_bit),    32'(0));
    endtask

    // Frame-level model: full-length frames deliver, others flag an error.
    task automatic model_frame_end(input logic [W-1:0] w, input int nbits);
        if (nbits == W) begin
            if (exp_valid && OVR_EN) exp_ovr = 1'b1;
            if (!exp_valid) exp_rises++;
            exp_dat   = w;
            exp_valid = 1'b1;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic do_ack();
        chk_en = 1'b0;
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(2);
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        chk_en    = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic [W-1:0] tx,
                              input int nbits, input int rst_at, output logic [W-1:0] mo);
        logic aborted;
        aborted = 1'b0;
        mo      = '0;
        STX_DAT = tx;
        chk_en  = 1'b0;
        LOAD    = 1'b0;
        MOSI    = w[W-1];
        tick(SET);
        exp_busy = 1'b1;
        chk_en   = 1'b1;
        tick(HALF - SET);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                chk_en = 1'b0;
                RESET  = 1'b0;
                #1;
                check_reset("midrst");
                tick(3);
                RESET     = 1'b1;
                exp_dat   = '0;
                exp_valid = 1'b0;
                exp_ovr   = 1'b0;
                exp_busy  = 1'b0;
                aborted   = 1'b1;
                tick(1);
                chk_en = 1'b1;
            end
            if (i > 0) begin
                MOSI = (i < W) ? w[W-1-i] : 1'b0;
                tick(HALF);
            end
            mo   = {mo[W-2:0], MISO};
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
        end
        tick(HALF);
        chk_en = 1'b0;
        LOAD   = 1'b1;
        tick(SET);
        if (!aborted) model_frame_end(w, nbits);
        exp_busy = 1'b0;
        chk_en   = 1'b1;
        tick(2);
    endtask

    initial begin
        RESET   = 1'b0;
        LOAD    = 1'b1;
        SCLK    = 1'b0;
        MOSI    = 1'b0;
        rx_ack  = 1'b0;
        STX_DAT = '0;
        tick(3);
        check_reset("rst");
        RESET = 1'b1;
        tick(10);
        chk_en = 1'b1;

        send_frame(16'h1234, 16'h5678, W, -1, mw);
        check("normal_miso",   32'(mw),       32'h5678);
        check("normal_srx",    32'(SRX_DAT),  32'h1234);
        check("normal_valid",  32'(rx_valid), 32'(1));
        check("normal_cb_bit", 32'(cb_bit),   32'd16);
        check("normal_ferr",   32'(ferr_cycles), 32'(0));

        send_frame(16'hFFFF, 16'hA5C3, 8, -1, mw);
        check("short_miso",   32'(mw[7:0]),    32'hA5);
        check("short_ferr",   32'(ferr_cycles), 32'(1));
        check("short_srx",    32'(SRX_DAT),    32'h1234);
        check("short_valid",  32'(rx_valid),   32'(1));
        check("short_cb_bit", 32'(cb_bit),     32'd8);
        do_ack();
        check("ack_valid", 32'(rx_valid), 32'(0));

        r0 = rv_rises;
        send_frame(16'hA5A5, 16'h3C3C, W, -1, mw);
        check("b2b1_miso", 32'(mw), 32'h3C3C);
        do_ack();
        send_frame(16'h0F0F, 16'hC3C3, W, -1, mw);
        check("b2b2_miso",   32'(mw),           32'hC3C3);
        check("b2b_rises",   32'(rv_rises - r0), 32'(2));
        check("b2b_srx",     32'(SRX_DAT),      32'h0F0F);
        check("b2b_overrun", 32'(overrun),      32'(0));
        do_ack();

        send_frame(16'h1357, 16'h0000, 20, -1, mw);
        check("long_ferr",   32'(ferr_cycles), 32'(exp_ferr));
        check("long_valid",  32'(rx_valid),    32'(0));
        check("long_cb_bit", 32'(cb_bit),      32'd20);

        send_frame(16'h1111, 16'h0001, W, -1, mw);
        send_frame(16'h2222, 16'h8000, W, -1, mw);
        check("ovr_miso",    32'(mw),       32'h8000);
        check("ovr_srx",     32'(SRX_DAT),  32'h2222);
        check("ovr_valid",   32'(rx_valid), 32'(1));
        check("ovr_flag",    32'(overrun),  32'(OVR_EN));
        do_ack();
        check("ovr_ack_valid", 32'(rx_valid), 32'(0));
        check("ovr_ack_flag",  32'(overrun),  32'(0));

        for (int k = 0; k < 4; k++) begin
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
            tick(HALF);
        end
        check("idle_sclk_cb_bit", 32'(cb_bit), 32'd16);
        check("idle_sclk_busy",   32'(busy),   32'(0));

        send_frame(16'h4242, 16'h0000, W, -1, mw);
        check("pre_rst_srx", 32'(SRX_DAT), 32'h4242);
        send_frame(16'hFFFF, 16'h9999, W, 5, mw);
        check("post_rst_srx",    32'(SRX_DAT),     32'(0));
        check("post_rst_valid",  32'(rx_valid),    32'(0));
        check("post_rst_cb_bit", 32'(cb_bit),      32'(0));
        check("post_rst_ferr",   32'(ferr_cycles), 32'(exp_ferr));
        send_frame(16'hBEEF, 16'h1234, W, -1, mw);
        check("beef_miso",  32'(mw),       32'h1234);
        check("beef_srx",   32'(SRX_DAT),  32'hBEEF);
        check("beef_valid", 32'(rx_valid), 32'(1));
        check("final_rises", 32'(rv_rises), 32'(exp_rises));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
